// File: rtl/beep_sequencer.sv
// beep_sequencer: queues single-cycle short/long beep requests in a small
// FIFO and plays them back in order as timed tone bursts on sonido/s_enable.
// Optional feature macro: BEEP_GAP_EN inserts a silent GAP state of
// GAP_CYCLES between consecutive tones. When it is undefined, queued tones
// play back to back and GAP_CYCLES is only range-checked.

module beep_sequencer #(
    parameter int unsigned         FREQ_W       = 52,
    parameter int unsigned         DUR_W        = 24,
    parameter logic [FREQ_W-1:0]   TONE_SHORT   = FREQ_W'(32000),
    parameter logic [FREQ_W-1:0]   TONE_LONG    = FREQ_W'(32000),
    parameter int unsigned         SHORT_CYCLES = 2500000,
    parameter int unsigned         LONG_CYCLES  = 10000000,
    parameter int unsigned         GAP_CYCLES   = 1250000,
    parameter int unsigned         QDEPTH_LOG2  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              short,
    input  logic              long,
    output logic [FREQ_W-1:0] sonido,
    output logic              s_enable,
    output logic              busy,
    output logic              full,
    output logic              dropped
);

    localparam int unsigned DEPTH = 1 << QDEPTH_LOG2;

    localparam logic [DUR_W-1:0]       SHORT_LOAD = DUR_W'(SHORT_CYCLES);
    localparam logic [DUR_W-1:0]       LONG_LOAD  = DUR_W'(LONG_CYCLES);
    localparam logic [DUR_W-1:0]       DUR_ONE    = DUR_W'(1);
    localparam logic [QDEPTH_LOG2-1:0] PTR_ONE    = QDEPTH_LOG2'(1);
    localparam logic [QDEPTH_LOG2:0]   CNT_ONE    = (QDEPTH_LOG2 + 1)'(1);
    localparam logic [QDEPTH_LOG2:0]   CNT_FULL   = (QDEPTH_LOG2 + 1)'(DEPTH);

`ifdef BEEP_GAP_EN
    localparam logic [DUR_W-1:0]       GAP_LOAD   = DUR_W'(GAP_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        TONE,
        GAP
    } state_t;
`else
    typedef enum logic {
        IDLE,
        TONE
    } state_t;
`endif

    // Elaboration-time sanity check: durations must be nonzero and fit the
    // down-counter, otherwise the reload-before-zero scheme breaks.
    generate
        if (QDEPTH_LOG2 == 0 ||
            SHORT_CYCLES == 0 || (SHORT_CYCLES >> DUR_W) != 0 ||
            LONG_CYCLES  == 0 || (LONG_CYCLES  >> DUR_W) != 0 ||
            GAP_CYCLES   == 0 || (GAP_CYCLES   >> DUR_W) != 0) begin : g_bad_params
            $error("beep_sequencer: duration or depth parameter out of range");
        end
    endgenerate

    state_t                 state;
    state_t                 next_state;
    logic [DUR_W-1:0]       dur_count;
    logic [DUR_W-1:0]       next_dur_count;
    logic                   tone_long;
    logic                   next_tone_long;

    logic                   fifo_mem [DEPTH];
    logic [QDEPTH_LOG2-1:0] wr_ptr;
    logic [QDEPTH_LOG2-1:0] rd_ptr;
    logic [QDEPTH_LOG2:0]   fifo_count;
    logic [QDEPTH_LOG2:0]   next_fifo_count;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   fifo_head;
    logic [DUR_W-1:0]       head_load;

    logic                   push_req;
    logic                   do_push;
    logic                   pop;
    logic                   drop;

    logic                   next_s_enable;
    logic [FREQ_W-1:0]      next_sonido;
    logic                   next_busy;
    logic                   next_full;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CNT_FULL);
    assign fifo_head  = fifo_mem[rd_ptr];
    assign head_load  = fifo_head ? LONG_LOAD : SHORT_LOAD;

    // Request acceptance: a held strobe pushes every enabled edge; a push into
    // a full FIFO only survives if a pop frees a slot on the same edge.
    always_comb begin
        push_req = enable & (short | long);
        do_push  = push_req & (~fifo_full | pop);
        drop     = push_req & fifo_full & ~pop;
    end

    // Sequencer next-state logic: pops the FIFO, loads and counts down the
    // duration counter, reloading at 1 so it never reaches zero mid-run.
    always_comb begin
        next_state     = state;
        next_dur_count = dur_count;
        next_tone_long = tone_long;
        pop            = 1'b0;

        if (enable) begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        pop            = 1'b1;
                        next_state     = TONE;
                        next_tone_long = fifo_head;
                        next_dur_count = head_load;
                    end
                end

                TONE: begin
                    if (dur_count == DUR_ONE) begin
`ifdef BEEP_GAP_EN
                        next_state     = GAP;
                        next_dur_count = GAP_LOAD;
`else
                        if (!fifo_empty) begin
                            pop            = 1'b1;
                            next_state     = TONE;
                            next_tone_long = fifo_head;
                            next_dur_count = head_load;
                        end else begin
                            next_state     = IDLE;
                            next_dur_count = '0;
                        end
`endif
                    end else if (dur_count != '0) begin
                        next_dur_count = dur_count - DUR_ONE;
                    end else begin
                        next_state = IDLE;
                    end
                end

`ifdef BEEP_GAP_EN
                GAP: begin
                    if (dur_count == DUR_ONE) begin
                        if (!fifo_empty) begin
                            pop            = 1'b1;
                            next_state     = TONE;
                            next_tone_long = fifo_head;
                            next_dur_count = head_load;
                        end else begin
                            next_state     = IDLE;
                            next_dur_count = '0;
                        end
                    end else if (dur_count != '0) begin
                        next_dur_count = dur_count - DUR_ONE;
                    end else begin
                        next_state = IDLE;
                    end
                end
`endif

                default: begin
                    next_state     = IDLE;
                    next_dur_count = '0;
                end
            endcase
        end
    end

    // FIFO occupancy bookkeeping for the next edge.
    always_comb begin
        next_fifo_count = fifo_count;
        case ({do_push, pop})
            2'b10:   next_fifo_count = fifo_count + CNT_ONE;
            2'b01:   next_fifo_count = fifo_count - CNT_ONE;
            default: next_fifo_count = fifo_count;
        endcase
    end

    // Output values for the next edge; silenced whenever enable is low.
    always_comb begin
        next_s_enable = enable & (next_state == TONE);
        next_sonido   = '0;
        if (next_s_enable) begin
            next_sonido = next_tone_long ? TONE_LONG : TONE_SHORT;
        end
        next_busy = (next_state != IDLE) | (next_fifo_count != '0);
        next_full = (next_fifo_count == CNT_FULL);
    end

    // Sequencer state, duration counter and current tone type.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            dur_count <= '0;
            tone_long <= 1'b0;
        end else begin
            state     <= next_state;
            dur_count <= next_dur_count;
            tone_long <= next_tone_long;
        end
    end

    // FIFO pointers, occupancy and storage (one type bit per entry, long=1).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem[i] <= 1'b0;
            end
        end else begin
            fifo_count <= next_fifo_count;
            if (do_push) begin
                fifo_mem[wr_ptr] <= long;
                wr_ptr           <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Registered outputs; async reset silences the tone immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sonido   <= '0;
            s_enable <= 1'b0;
            busy     <= 1'b0;
            full     <= 1'b0;
            dropped  <= 1'b0;
        end else begin
            sonido   <= next_sonido;
            s_enable <= next_s_enable;
            busy     <= next_busy;
            full     <= next_full;
            dropped  <= drop;
        end
    end

endmodule

// File: tb/tb_beep_sequencer.sv
// Testbench for beep_sequencer: directed scenarios, expected tone segments
// queued when the stimulus is driven and compared against segments recorded
// from the outputs. Adapts expectations to the BEEP_GAP_EN build option.

module tb_beep_sequencer;

    localparam int unsigned FREQ_W = 16;
    localparam int unsigned DUR_W  = 8;
    localparam logic [FREQ_W-1:0] T_SHORT = 16'd1000;
    localparam logic [FREQ_W-1:0] T_LONG  = 16'd2000;
    localparam int S_CYC = 4;
    localparam int L_CYC = 6;
    localparam int G_CYC = 2;

`ifdef BEEP_GAP_EN
    localparam bit GAP_MODE = 1'b1;
`else
    localparam bit GAP_MODE = 1'b0;
`endif

    typedef struct {
        logic [FREQ_W-1:0] val;
        int                len;
        int                gap;
    } seg_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              short;
    logic              long;
    logic [FREQ_W-1:0] sonido;
    logic              s_enable;
    logic              busy;
    logic              full;
    logic              dropped;

    int   tests_run  = 0;
    int   fail_count = 0;
    seg_t exp_q[$];
    seg_t obs_q[$];
    int   drop_count = 0;
    bit   full_seen  = 1'b0;

    beep_sequencer #(
        .FREQ_W      (FREQ_W),
        .DUR_W       (DUR_W),
        .TONE_SHORT  (T_SHORT),
        .TONE_LONG   (T_LONG),
        .SHORT_CYCLES(S_CYC),
        .LONG_CYCLES (L_CYC),
        .GAP_CYCLES  (G_CYC),
        .QDEPTH_LOG2 (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .short   (short),
        .long    (long),
        .sonido  (sonido),
        .s_enable(s_enable),
        .busy    (busy),
        .full    (full),
        .dropped (dropped)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    // Drive strobes starting right after a negedge, hold for n edges.
    task automatic applyStimulus(input logic s, input logic l, input int n);
        short = s;
        long  = l;
        repeat (n) @(negedge clk);
        short = 1'b0;
        long  = 1'b0;
    endtask

    task automatic push_exp(input logic [FREQ_W-1:0] v, input int len, input int gap);
        seg_t e;
        e.val = v;
        e.len = len;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_busy_idle"}, busy, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic drain_check(input string tag);
        seg_t e;
        seg_t o;
        checkOutput({tag, "_seg_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checkOutput({tag, "_sonido"}, o.val, e.val);
            checkOutput({tag, "_length"}, o.len, e.len);
            if (e.gap >= 0) begin
                checkOutput({tag, "_gap"}, o.gap, e.gap);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    // Output monitor: records each run of s_enable with a constant sonido as
    // a segment, together with the silent cycles that preceded it.
    initial begin
        int                run_len = 0;
        int                low_len = 0;
        int                run_gap = 0;
        logic [FREQ_W-1:0] run_val = '0;
        seg_t              s;
        forever begin
            @(negedge clk);
            if (dropped === 1'b1) drop_count++;
            if (full === 1'b1) full_seen = 1'b1;
            if (s_enable === 1'b1) begin
                if (run_len != 0 && sonido !== run_val) begin
                    s.val = run_val; s.len = run_len; s.gap = run_gap;
                    obs_q.push_back(s);
                    run_len = 0;
                    low_len = 0;
                end
                if (run_len == 0) begin
                    run_val = sonido;
                    run_gap = low_len;
                end
                run_len++;
                low_len = 0;
            end else begin
                checkOutput("silent_sonido", sonido, '0);
                if (run_len != 0) begin
                    s.val = run_val; s.len = run_len; s.gap = run_gap;
                    obs_q.push_back(s);
                    run_len = 0;
                end
                low_len++;
            end
        end
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        short  = 1'b0;
        long   = 1'b0;
        #1;
        checkOutput("rst_sonido", sonido, '0);
        checkOutput("rst_s_enable", s_enable, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_full", full, 1'b0);
        checkOutput("rst_dropped", dropped, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single short beep: latency and tone length
        $display("[TB] single short beep");
        @(negedge clk);
        push_exp(T_SHORT, S_CYC, -1);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("lat_before", s_enable, 1'b0);
        checkOutput("busy_after_push", busy, 1'b1);
        @(negedge clk);
        checkOutput("lat_s_enable", s_enable, 1'b1);
        checkOutput("lat_sonido", sonido, T_SHORT);
        wait_idle("single");
        drain_check("single");

        // Short then long on consecutive cycles
        $display("[TB] short then long");
        @(negedge clk);
        push_exp(T_SHORT, S_CYC, -1);
        push_exp(T_LONG, L_CYC, GAP_MODE ? G_CYC : 0);
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 1);
        wait_idle("sl");
        drain_check("sl");

        // Both strobes together: one long entry
        $display("[TB] short and long together");
        @(negedge clk);
        push_exp(T_LONG, L_CYC, -1);
        applyStimulus(1'b1, 1'b1, 1);
        wait_idle("both");
        drain_check("both");

        // Overfill: six requests, depth four, one drop
        $display("[TB] fifo overflow");
        @(negedge clk);
        drop_count = 0;
        full_seen  = 1'b0;
        push_exp(T_LONG, L_CYC, -1);
        applyStimulus(1'b0, 1'b1, 1);
        if (GAP_MODE) begin
            for (int i = 0; i < 4; i++) push_exp(T_SHORT, S_CYC, G_CYC);
        end else begin
            push_exp(T_SHORT, 4 * S_CYC, 0);
        end
        applyStimulus(1'b1, 1'b0, 5);
        wait_idle("ovf");
        checkOutput("ovf_full_seen", full_seen, 1'b1);
        checkOutput("ovf_drop_count", drop_count, 1);
        checkOutput("ovf_full_end", full, 1'b0);
        drain_check("ovf");

        // Enable low for three cycles mid-tone
        $display("[TB] enable pause");
        @(negedge clk);
        push_exp(T_SHORT, 2, -1);
        push_exp(T_SHORT, S_CYC - 2, 3);
        applyStimulus(1'b1, 1'b0, 1);
        @(negedge clk);
        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("pause_s_enable", s_enable, 1'b0);
            checkOutput("pause_sonido", sonido, '0);
            checkOutput("pause_busy", busy, 1'b1);
        end
        enable = 1'b1;
        wait_idle("pause");
        drain_check("pause");

        // Reset mid-tone with queued entries
        $display("[TB] reset mid-tone");
        @(negedge clk);
        push_exp(T_SHORT, 3, -1);
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 2);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrst_s_enable", s_enable, 1'b0);
        checkOutput("midrst_sonido", sonido, '0);
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_full", full, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("postrst_busy", busy, 1'b0);
        drain_check("midrst");

        // Two queued shorts: contiguous without gap, separated with gap
        $display("[TB] two shorts");
        @(negedge clk);
        if (GAP_MODE) begin
            push_exp(T_SHORT, S_CYC, -1);
            push_exp(T_SHORT, S_CYC, G_CYC);
        end else begin
            push_exp(T_SHORT, 2 * S_CYC, -1);
        end
        applyStimulus(1'b1, 1'b0, 2);
        wait_idle("two");
        drain_check("two");

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
